sparse_decompression: RTL and testbench

//  Consumes one compressed vector (packed non-zero values + 16-bit occupancy bitmap) from
//  the sparse compression stage and rebuilds the dense 16-lane vector for the PE array.

---
 rtl/sparse_decompression_pkg.sv | 28 ++
 rtl/sparse_decompression_if.sv | 26 ++
 rtl/sparse_group_expand.sv | 32 +++
 rtl/sparse_decompression.sv | 117 +++++++++++
 tb/tb_sparse_decompression.sv | 352 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/sparse_decompression_pkg.sv
// Shared constants, types and state encodings for the sparse decompression block.
package sparse_decompression_pkg;

  localparam int unsigned DATA_WIDTH   = 16;
  localparam int unsigned SPARSE_LANES = 16;
  localparam int unsigned SPARSE_NNZ_W = 5;
  localparam int unsigned SPARSE_IDX_W = 4;
  localparam int unsigned SPARSE_LPC   = 4;

  localparam logic [1:0] DEC_IDLE   = 2'd0;
  localparam logic [1:0] DEC_EXPAND = 2'd1;
  localparam logic [1:0] DEC_OUTPUT = 2'd2;

  typedef logic [DATA_WIDTH-1:0] lane_t;
  typedef lane_t [SPARSE_LANES-1:0] vec_t;

  // Add two lane counts, clamping at SPARSE_LANES (the read pointer never points past the end).
  function automatic logic [SPARSE_NNZ_W-1:0] sat_add(input logic [SPARSE_NNZ_W-1:0] a,
                                                      input logic [SPARSE_NNZ_W-1:0] b);
    logic [SPARSE_NNZ_W:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    if (sum > (SPARSE_NNZ_W + 1)'(SPARSE_LANES)) begin
      return SPARSE_NNZ_W'(SPARSE_LANES);
    end
    return sum[SPARSE_NNZ_W-1:0];
  endfunction

endpackage

// File: rtl/sparse_decompression_if.sv
// Upstream (compressed) and downstream (dense) handshake channels of the decompressor.
interface sparse_decompression_if;
  import sparse_decompression_pkg::*;

  vec_t                    data_in;
  logic [SPARSE_LANES-1:0] index_in;
  logic                    valid_in;
  logic                    ready_in;
  vec_t                    data_out;
  logic [SPARSE_NNZ_W-1:0] nnz_out;
  logic                    valid_out;
  logic                    ready_out;

  // Environment side: produces compressed vectors and consumes dense ones.
  modport master (
    output data_in, index_in, valid_in, ready_out,
    input  ready_in, data_out, nnz_out, valid_out
  );

  // Decompressor side.
  modport slave (
    input  data_in, index_in, valid_in, ready_out,
    output ready_in, data_out, nnz_out, valid_out
  );

endinterface

// File: rtl/sparse_group_expand.sv
// Combinational expansion of one group of dense lanes from the packed non-zero list.
module sparse_group_expand
  import sparse_decompression_pkg::*;
#(
  parameter int unsigned Lpc = SPARSE_LPC
) (
  input  vec_t                    packed_vals,
  input  logic [SPARSE_NNZ_W-1:0] rd_ptr,
  input  logic [Lpc-1:0]          bits,
  output lane_t [Lpc-1:0]         vals,
  output logic [SPARSE_NNZ_W-1:0] group_cnt
);

  logic [SPARSE_NNZ_W:0] offset;
  logic [SPARSE_NNZ_W:0] idx;

  // Each set lane takes packed[rd_ptr + set bits below it]; out-of-range reads give 0.
  always_comb begin
    vals   = '0;
    offset = '0;
    idx    = '0;
    for (int unsigned l = 0; l < Lpc; l++) begin
      idx = {1'b0, rd_ptr} + offset;
      if (bits[l] && (idx < (SPARSE_NNZ_W + 1)'(SPARSE_LANES))) begin
        vals[l] = packed_vals[idx[SPARSE_IDX_W-1:0]];
      end
      offset = offset + {{SPARSE_NNZ_W{1'b0}}, bits[l]};
    end
    group_cnt = offset[SPARSE_NNZ_W-1:0];
  end

endmodule

// File: rtl/sparse_decompression.sv
// Rebuilds a dense 16-lane vector from packed non-zeros plus an occupancy bitmap,
// LANES_PER_CYCLE lanes per cycle, with valid/ready on both sides.
module sparse_decompression
  import sparse_decompression_pkg::*;
#(
  // Must divide SPARSE_LANES.
  parameter int unsigned LANES_PER_CYCLE = SPARSE_LPC
) (
  input logic                   clk,
  input logic                   rst_n,
  sparse_decompression_if.slave bus
);

  localparam int unsigned Groups = SPARSE_LANES / LANES_PER_CYCLE;
  localparam int unsigned GrpW   = (Groups > 1) ? $clog2(Groups) : 1;
  localparam logic [GrpW-1:0] LastGrp = GrpW'(Groups - 1);

  logic [1:0]              state_q, state_d;
  logic [GrpW-1:0]         grp_q, grp_d;
  logic [SPARSE_NNZ_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [SPARSE_NNZ_W-1:0] nnz_q, nnz_d;
  vec_t                    data_out_q, data_out_d;
  vec_t                    data_q;
  logic [SPARSE_LANES-1:0] index_q;
  logic                    capture;

  logic [SPARSE_IDX_W-1:0]    lane_base;
  logic [LANES_PER_CYCLE-1:0] grp_bits;
  lane_t [LANES_PER_CYCLE-1:0] grp_vals;
  logic [SPARSE_NNZ_W-1:0]    grp_cnt;

  assign lane_base = SPARSE_IDX_W'(grp_q * LANES_PER_CYCLE);
  assign grp_bits  = index_q[lane_base +: LANES_PER_CYCLE];

  sparse_group_expand #(
    .Lpc(LANES_PER_CYCLE)
  ) u_group_expand (
    .packed_vals(data_q),
    .rd_ptr     (rd_ptr_q),
    .bits       (grp_bits),
    .vals       (grp_vals),
    .group_cnt  (grp_cnt)
  );

  // FSM next state, group walk and dense output assembly.
  always_comb begin
    state_d    = state_q;
    grp_d      = grp_q;
    rd_ptr_d   = rd_ptr_q;
    nnz_d      = nnz_q;
    data_out_d = data_out_q;
    capture    = 1'b0;
    case (state_q)
      DEC_IDLE: begin
        if (bus.valid_in) begin
          capture    = 1'b1;
          data_out_d = '0;
          nnz_d      = '0;
          grp_d      = '0;
          rd_ptr_d   = '0;
          state_d    = DEC_EXPAND;
        end
      end
      DEC_EXPAND: begin
        for (int unsigned l = 0; l < LANES_PER_CYCLE; l++) begin
          data_out_d[int'(lane_base) + int'(l)] = grp_vals[l];
        end
        rd_ptr_d = sat_add(rd_ptr_q, grp_cnt);
        nnz_d    = nnz_q + grp_cnt;
        grp_d    = grp_q + GrpW'(1);
        if (grp_q == LastGrp) begin
          state_d = DEC_OUTPUT;
        end
      end
      DEC_OUTPUT: begin
        if (bus.ready_out) begin
          state_d = DEC_IDLE;
        end
      end
      default: state_d = DEC_IDLE;
    endcase
  end

  // Control and output registers; reset drops any vector in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= DEC_IDLE;
      grp_q      <= '0;
      rd_ptr_q   <= '0;
      nnz_q      <= '0;
      data_out_q <= '0;
    end else begin
      state_q    <= state_d;
      grp_q      <= grp_d;
      rd_ptr_q   <= rd_ptr_d;
      nnz_q      <= nnz_d;
      data_out_q <= data_out_d;
    end
  end

  // Capture registers; expansion only ever reads these, so upstream may change freely.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q  <= '0;
      index_q <= '0;
    end else if (capture) begin
      data_q  <= bus.data_in;
      index_q <= bus.index_in;
    end
  end

  assign bus.data_out  = data_out_q;
  assign bus.nnz_out   = nnz_q;
  assign bus.valid_out = (state_q == DEC_OUTPUT);
  assign bus.ready_in  = (state_q == DEC_IDLE);

endmodule

// File: tb/tb_sparse_decompression.sv
// Self-checking bench for sparse_decompression against a bitmap-walk reference model.
module tb_sparse_decompression;
  import sparse_decompression_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sparse_decompression_if bus_if ();

  sparse_decompression #(
    .LANES_PER_CYCLE(4)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus_if)
  );

  int checks = 0;
  int errors = 0;

  // Reference: walk the bitmap, handing out packed values in ascending lane order.
  function automatic vec_t model_dense(input vec_t pk, input logic [15:0] idx);
    vec_t d;
    int   k;
    d = '0;
    k = 0;
    for (int i = 0; i < 16; i++) begin
      if (idx[i]) begin
        d[i] = pk[k];
        k++;
      end
    end
    return d;
  endfunction

  function automatic logic [4:0] model_nnz(input logic [15:0] idx);
    return 5'($countones(idx));
  endfunction

  function automatic vec_t rand_vec();
    vec_t v;
    for (int i = 0; i < 16; i++) v[i] = 16'($urandom);
    return v;
  endfunction

  function automatic logic [15:0] rand_index();
    logic [15:0] r;
    case ($urandom_range(0, 3))
      0: r = 16'($urandom);
      1: r = 16'($urandom) & 16'($urandom) & 16'($urandom);
      2: r = ~(16'($urandom) & 16'($urandom));
      default: r = 16'(1) << $urandom_range(0, 15);
    endcase
    return r;
  endfunction

  // Present one vector in IDLE and hold it for exactly the accepting edge, then scramble inputs.
  task automatic accept_vector(input vec_t d, input logic [15:0] idx);
    @(negedge clk);
    bus_if.data_in  = d;
    bus_if.index_in = idx;
    bus_if.valid_in = 1'b1;
    @(posedge clk);
    #1;
    bus_if.valid_in = 1'b0;
    bus_if.data_in  = rand_vec();
    bus_if.index_in = 16'($urandom);
  endtask

  // Cycles from the accept cycle (cycle 0) to the first cycle showing valid_out; -1 on timeout.
  task automatic wait_valid(output int lat);
    lat = 0;
    while (lat < 20) begin
      @(negedge clk);
      lat++;
      if (bus_if.valid_out === 1'b1) break;
    end
    if (bus_if.valid_out !== 1'b1) lat = -1;
  endtask

  task automatic release_output();
    bus_if.ready_out = 1'b1;
    @(posedge clk);
    #1;
    bus_if.ready_out = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    bus_if.valid_in  = 1'b0;
    bus_if.ready_out = 1'b0;
    bus_if.data_in   = '0;
    bus_if.index_in  = '0;
    rst_n = 1'b0;
    @(negedge clk);
    checks++;
    if (bus_if.valid_out !== 1'b0 || bus_if.ready_in !== 1'b1) begin
      errors++;
      $display("FAIL reset_handshake: valid_out=%b ready_in=%b, required 0/1",
               bus_if.valid_out, bus_if.ready_in);
    end
    checks++;
    if (bus_if.data_out !== '0 || bus_if.nnz_out !== 5'd0) begin
      errors++;
      $display("FAIL reset_data: data_out=%h nnz=%0d, required 0/0",
               bus_if.data_out, bus_if.nnz_out);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_directed();
    vec_t        d;
    logic [15:0] idx;
    int          lat;
    for (int c = 0; c < 4; c++) begin
      d = rand_vec();
      case (c)
        0: begin idx = 16'h0000; for (int i = 0; i < 16; i++) d[i] = 16'(i + 1); end
        1: begin idx = 16'hFFFF; for (int i = 0; i < 16; i++) d[i] = 16'(i + 1); end
        2: begin idx = 16'h8421; d[0] = 16'h000A; d[1] = 16'h000B; d[2] = 16'h000C;
                 d[3] = 16'h000D; end
        default: begin idx = 16'h00F0; for (int i = 0; i < 4; i++) d[i] = 16'(i + 1); end
      endcase
      accept_vector(d, idx);
      wait_valid(lat);
      checks++;
      if (lat !== 5) begin
        errors++;
        $display("FAIL directed%0d_latency: got %0d cycles, required 5", c, lat);
      end
      checks++;
      if (bus_if.data_out !== model_dense(d, idx)) begin
        errors++;
        $display("FAIL directed%0d_data: got %h, required %h", c, bus_if.data_out,
                 model_dense(d, idx));
      end
      checks++;
      if (bus_if.nnz_out !== model_nnz(idx)) begin
        errors++;
        $display("FAIL directed%0d_nnz: got %0d, required %0d", c, bus_if.nnz_out,
                 model_nnz(idx));
      end
      if (c == 1) begin
        checks++;
        if (bus_if.data_out !== d) begin
          errors++;
          $display("FAIL directed_identity: got %h, required %h", bus_if.data_out, d);
        end
      end
      if (c == 2) begin
        checks++;
        if (bus_if.data_out[10] !== 16'h000C || bus_if.data_out[15] !== 16'h000D) begin
          errors++;
          $display("FAIL directed_8421_lanes: lane10=%h lane15=%h, required 000c/000d",
                   bus_if.data_out[10], bus_if.data_out[15]);
        end
      end
      release_output();
      checks++;
      if (bus_if.valid_out !== 1'b0 || bus_if.ready_in !== 1'b1) begin
        errors++;
        $display("FAIL directed%0d_release: valid_out=%b ready_in=%b, required 0/1", c,
                 bus_if.valid_out, bus_if.ready_in);
      end
    end
  endtask

  task automatic test_backpressure();
    vec_t        d;
    logic [15:0] idx;
    vec_t        exp_d;
    int          lat;
    d     = rand_vec();
    idx   = rand_index();
    exp_d = model_dense(d, idx);
    accept_vector(d, idx);
    wait_valid(lat);
    checks++;
    if (lat !== 5) begin
      errors++;
      $display("FAIL stall_latency: got %0d cycles, required 5", lat);
    end
    // Upstream keeps offering a new vector; it must be ignored until the output drains.
    bus_if.valid_in = 1'b1;
    for (int k = 0; k < 10; k++) begin
      checks++;
      if (bus_if.valid_out !== 1'b1 || bus_if.ready_in !== 1'b0 ||
          bus_if.data_out !== exp_d || bus_if.nnz_out !== model_nnz(idx)) begin
        errors++;
        $display("FAIL stall_hold cycle %0d: valid=%b ready_in=%b nnz=%0d data=%h, required 1/0/%0d/%h",
                 k, bus_if.valid_out, bus_if.ready_in, bus_if.nnz_out, bus_if.data_out,
                 model_nnz(idx), exp_d);
      end
      @(negedge clk);
    end
    bus_if.valid_in = 1'b0;
    release_output();
    checks++;
    if (bus_if.valid_out !== 1'b0 || bus_if.ready_in !== 1'b1) begin
      errors++;
      $display("FAIL stall_release: valid_out=%b ready_in=%b, required 0/1",
               bus_if.valid_out, bus_if.ready_in);
    end
  endtask

  task automatic test_reset_mid();
    vec_t        d;
    logic [15:0] idx;
    int          lat;
    d = rand_vec();
    d[0] = 16'h1234;
    accept_vector(d, 16'hFFFF);
    // Cycle 3 after accept: group 2 is being expanded, lanes 0..7 already written.
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus_if.valid_out !== 1'b0 || bus_if.ready_in !== 1'b1 ||
        bus_if.data_out !== '0 || bus_if.nnz_out !== 5'd0) begin
      errors++;
      $display("FAIL midreset_clear: valid=%b ready_in=%b nnz=%0d data=%h, required 0/1/0/0",
               bus_if.valid_out, bus_if.ready_in, bus_if.nnz_out, bus_if.data_out);
    end
    @(negedge clk);
    rst_n = 1'b1;
    d   = rand_vec();
    idx = rand_index();
    accept_vector(d, idx);
    wait_valid(lat);
    checks++;
    if (lat !== 5 || bus_if.data_out !== model_dense(d, idx) ||
        bus_if.nnz_out !== model_nnz(idx)) begin
      errors++;
      $display("FAIL midreset_next: lat=%0d nnz=%0d data=%h, required 5/%0d/%h", lat,
               bus_if.nnz_out, bus_if.data_out, model_nnz(idx), model_dense(d, idx));
    end
    release_output();
  endtask

  task automatic test_random();
    vec_t        d;
    logic [15:0] idx;
    int          lat;
    int          stall;
    for (int n = 0; n < 25; n++) begin
      d     = rand_vec();
      idx   = rand_index();
      stall = $urandom_range(0, 3);
      accept_vector(d, idx);
      wait_valid(lat);
      checks++;
      if (lat !== 5) begin
        errors++;
        $display("FAIL random%0d_latency: got %0d, required 5 (index %h)", n, lat, idx);
      end
      repeat (stall) @(negedge clk);
      checks++;
      if (bus_if.data_out !== model_dense(d, idx)) begin
        errors++;
        $display("FAIL random%0d_data: index %h got %h, required %h", n, idx,
                 bus_if.data_out, model_dense(d, idx));
      end
      checks++;
      if (bus_if.nnz_out !== model_nnz(idx)) begin
        errors++;
        $display("FAIL random%0d_nnz: index %h got %0d, required %0d", n, idx,
                 bus_if.nnz_out, model_nnz(idx));
      end
      release_output();
    end
  endtask

  task automatic test_back_to_back();
    vec_t        exp_q[$];
    logic [4:0]  nnz_exp_q[$];
    int          accepted;
    int          outs;
    int          prev_acc;
    bit          took;
    accepted = 0;
    outs     = 0;
    prev_acc = -1;
    @(negedge clk);
    bus_if.ready_out = 1'b1;
    bus_if.valid_in  = 1'b1;
    bus_if.data_in   = rand_vec();
    bus_if.index_in  = rand_index();
    for (int c = 0; c < 60 && outs < 4; c++) begin
      if (c > 0) @(negedge clk);
      took = 1'b0;
      if (bus_if.valid_out === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL b2b_spurious: valid_out with no vector outstanding");
        end else if (bus_if.data_out !== exp_q[0] || bus_if.nnz_out !== nnz_exp_q[0]) begin
          errors++;
          $display("FAIL b2b_data%0d: nnz=%0d data=%h, required %0d/%h", outs,
                   bus_if.nnz_out, bus_if.data_out, nnz_exp_q[0], exp_q[0]);
        end
        if (exp_q.size() != 0) begin
          void'(exp_q.pop_front());
          void'(nnz_exp_q.pop_front());
        end
        outs++;
      end
      if (bus_if.valid_in === 1'b1 && bus_if.ready_in === 1'b1) begin
        exp_q.push_back(model_dense(bus_if.data_in, bus_if.index_in));
        nnz_exp_q.push_back(model_nnz(bus_if.index_in));
        if (prev_acc >= 0) begin
          checks++;
          if (c - prev_acc !== 6) begin
            errors++;
            $display("FAIL b2b_spacing: accepts %0d cycles apart, required 6", c - prev_acc);
          end
        end
        prev_acc = c;
        accepted++;
        took = 1'b1;
      end
      @(posedge clk);
      #1;
      if (took) begin
        bus_if.data_in  = rand_vec();
        bus_if.index_in = rand_index();
      end
      if (accepted >= 4) bus_if.valid_in = 1'b0;
    end
    checks++;
    if (outs !== 4 || accepted !== 4) begin
      errors++;
      $display("FAIL b2b_count: %0d accepted, %0d delivered, required 4/4", accepted, outs);
    end
    bus_if.ready_out = 1'b0;
    bus_if.valid_in  = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_reset_mid();
    test_random();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
